// File: rtl/pooling_2d_stream.sv
// Streaming 2x2 stride-2 max/average pooling over a raster-order feature map.
// Define POOL_AVG_EN to enable the runtime-selectable average path (mode port).
module pooling_2d_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 20
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              valid_in,
  input  logic              mode,
  output logic [DATA_W-1:0] result,
  output logic              valid_out,
  output logic              frame_done
);

  localparam int HW = IMG_W / 2;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IW = (HW > 1) ? $clog2(HW) : 1;
`ifdef POOL_AVG_EN
  localparam int LW = DATA_W + 1;
  localparam int VW = DATA_W + 2;
`else
  localparam int LW = DATA_W;
`endif

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] h_hold_q, h_hold_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [LW-1:0]     lbuf_q [HW];
  logic              lbuf_we;
  logic [IW-1:0]     lidx;

  logic signed [DATA_W-1:0] hh, sd, h_max;
  logic signed [LW-1:0]     h, lb, v_max;
  logic [DATA_W-1:0]        res_v;
  logic                     col_last, row_last;

  assign hh       = h_hold_q;
  assign sd       = s_data;
  assign h_max    = (hh > sd) ? hh : sd;
  assign lidx     = IW'(col_q >> 1);
  assign lb       = lbuf_q[lidx];
  assign v_max    = (lb > h) ? lb : h;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));

`ifdef POOL_AVG_EN
  logic              mode_q, mode_d;
  logic signed [LW-1:0] h_sum;
  logic signed [VW-1:0] v_sum, v_shr;
  logic              unused_avg;

  assign h_sum = LW'(hh) + LW'(sd);
  assign h     = mode_q ? h_sum : LW'(h_max);
  assign v_sum = VW'(lb) + VW'(h);
  assign v_shr = v_sum >>> 2;
  assign res_v = mode_q ? v_shr[DATA_W-1:0] : v_max[DATA_W-1:0];
  assign unused_avg = ^{v_shr[VW-1:DATA_W], v_max[LW-1]};

  // Frame mode is latched on pixel (0,0) only
  always_comb begin
    mode_d = mode_q;
    if (valid_in && col_q == '0 && row_q == '0) mode_d = mode;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end
`else
  logic unused_mode;

  assign h           = h_max;
  assign res_v       = v_max;
  assign unused_mode = mode;
`endif

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    h_hold_d = h_hold_q;
    result_d = result_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    lbuf_we  = 1'b0;
    if (valid_in) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) row_d = row_last ? '0 : row_q + RW'(1);
      if (!col_q[0]) begin
        h_hold_d = s_data;
      end else if (!row_q[0]) begin
        lbuf_we = 1'b1;
      end else begin
        valid_d  = 1'b1;
        done_d   = col_last && row_last;
        result_d = res_v;
      end
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      h_hold_q <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      h_hold_q <= h_hold_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Even rows always refill an entry before the odd row reads it
  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf_q[lidx] <= h;
  end

  assign result     = result_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pooling_2d_stream.sv
// Self-checking bench for pooling_2d_stream: frame-level pooling model plus
// directed vectors with literal expectations.
module tb_pooling_2d_stream;

  localparam int DW = 16;
  localparam int W  = 24;
  localparam int H  = 20;
  localparam int N  = W * H;
`ifdef POOL_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          valid_in = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] result;
  logic          valid_out;
  logic          frame_done;

  pooling_2d_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .Rst_n(Rst_n), .s_data(s_data), .valid_in(valid_in),
    .mode(mode), .result(result), .valid_out(valid_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int pix [H][W];
  int px = 0;
  bit mode_f = 1'b0;
  bit exp_v = 1'b0;
  bit exp_done = 1'b0;
  int last_res = 0;

  int got_q [$];
  int done_cnt = 0;
  int done_res = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int qat(input int i);
    if (i >= 0 && i < got_q.size()) return got_q[i];
    return -999999;
  endfunction

  // Frame-level model: store pixels, pool each completed 2x2 window
  task automatic model_step(input int d, input bit v, input bit m);
    int r, c, s;
    exp_v = 1'b0;
    exp_done = 1'b0;
    if (!v) return;
    r = px / W;
    c = px % W;
    if (px == 0) mode_f = m & AVG;
    pix[r][c] = d;
    if (r % 2 == 1 && c % 2 == 1) begin
      if (mode_f) begin
        s = pix[r-1][c-1] + pix[r-1][c] + pix[r][c-1] + d;
        s = s >>> 2;
      end else begin
        s = pix[r-1][c-1];
        if (pix[r-1][c] > s) s = pix[r-1][c];
        if (pix[r][c-1] > s) s = pix[r][c-1];
        if (d > s) s = d;
      end
      exp_v = 1'b1;
      last_res = s;
      exp_done = (px == N - 1);
    end
    px = (px + 1) % N;
  endtask

  task automatic send(input int d, input bit v);
    @(negedge clk);
    s_data = DW'(d);
    valid_in = v;
    @(posedge clk);
    model_step(d, v, mode);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 1'b0);
  endtask

  task automatic clear();
    got_q.delete();
    done_cnt = 0;
    done_res = 0;
  endtask

  task automatic do_reset();
    #3;
    valid_in = 1'b0;
    Rst_n = 1'b0;
    exp_v = 1'b0;
    exp_done = 1'b0;
    last_res = 0;
    px = 0;
    @(posedge clk);
    #3;
    Rst_n = 1'b1;
  endtask

  task automatic send_frame(input int kind, input int base);
    int d;
    for (int i = 0; i < N; i++) begin
      d = 0;
      case (kind)
        0: d = base + i;
        1: if (i == 0) d = -1; else if (i == 1) d = -2;
           else if (i == W) d = -3; else if (i == W + 1) d = -4;
        default: d = 32767;
      endcase
      send(d, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    chk("valid_out", int'(valid_out), int'(exp_v));
    chk("frame_done", int'(frame_done), int'(exp_done));
    chk("result", int'($signed(result)), last_res);
    if (valid_out) got_q.push_back(int'($signed(result)));
    if (frame_done) begin
      done_cnt++;
      done_res = int'($signed(result));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", int'(result), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_done", int'(frame_done), 0);
    #2;
    Rst_n = 1'b1;

    // max ramp
    clear();
    mode = 1'b0;
    send_frame(0, 0);
    idle(2);
    chk("t1_count", got_q.size(), 120);
    chk("t1_first", qat(0), 25);
    chk("t1_k3j5", qat(3 * 12 + 5), 179);
    chk("t1_last", qat(119), 479);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_res", done_res, 479);

    // average ramp
    clear();
    mode = 1'b1;
    send_frame(0, 0);
    idle(2);
    chk("t2_first", qat(0), AVG ? 12 : 25);
    chk("t2_last", qat(119), AVG ? 466 : 479);

    // negative and saturating windows
    clear();
    mode = 1'b0;
    send_frame(1, 0);
    idle(2);
    chk("t3_neg_max", qat(0), -1);
    clear();
    mode = 1'b1;
    send_frame(1, 0);
    idle(2);
    chk("t3_neg_avg", qat(0), AVG ? -3 : -1);
    clear();
    send_frame(2, 0);
    idle(2);
    chk("t3_full_avg", qat(0), 32767);

    // gapped ramp
    clear();
    mode = 1'b0;
    for (int i = 0; i < N; i++) begin
      send(i, 1'b1);
      send(12345, 1'b0);
    end
    idle(2);
    chk("t4_count", got_q.size(), 120);
    chk("t4_first", qat(0), 25);
    chk("t4_last", qat(119), 479);

    // reset mid-frame
    for (int i = 0; i < 100; i++) send(i, 1'b1);
    do_reset();
    clear();
    send_frame(0, 0);
    idle(2);
    chk("t5_count", got_q.size(), 120);
    chk("t5_first", qat(0), 25);

    // back-to-back frames, mode changes mid-frame 1
    clear();
    mode = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (i == 300) mode = 1'b1;
      send(i, 1'b1);
    end
    idle(2);
    chk("t6_count", got_q.size(), 240);
    chk("t6_f1_last", qat(119), 479);
    chk("t6_f2_first", qat(120), AVG ? 492 : 505);
    chk("t6_done_cnt", done_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
